// File: rtl/cnn_layer_accel_fas_rd_arb_pkg.sv
// Shared definitions for the FAS read arbiter: client IDs, FSM state, tag type.
package cnn_layer_accel_fas_rd_arb_pkg;

  localparam int unsigned C_IM_SM_RD_ID = 0;
  localparam int unsigned C_PM_SM_RD_ID = 1;
  localparam int unsigned C_PV_SM_RD_ID = 2;
  localparam int unsigned C_RM_SM_RD_ID = 3;
  localparam int unsigned SM_RD_NUM     = 4;

  typedef logic [$clog2(SM_RD_NUM)-1:0] rd_tag_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } arb_state_e;

  // Round-robin successor of a client ID, wrapping at n.
  function automatic rd_tag_t rr_next(rd_tag_t cur, int unsigned n);
    return rd_tag_t'((32'(cur) + 32'd1) % n);
  endfunction

endpackage

// File: rtl/cnn_layer_accel_fas_rd_arb_tag_fifo.sv
// Synchronous FIFO of read tags recording bursts in issue order.
module cnn_layer_accel_fas_rd_arb_tag_fifo
  import cnn_layer_accel_fas_rd_arb_pkg::*;
#(
  parameter int unsigned C_DEPTH = 8   // power of 2, >= 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  rd_tag_t                    push_tag,
  input  logic                       pop,
  output rd_tag_t                    head_tag,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(C_DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(C_DEPTH);
  localparam int unsigned CW = PW + 1;

  rd_tag_t         mem_q [C_DEPTH];
  rd_tag_t         mem_d [C_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push_ok, pop_ok;

  assign full     = (count_q == CW'(C_DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign head_tag = mem_q[rd_ptr_q];

  // Pointer/count update; a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    push_ok  = push & ~full;
    pop_ok   = pop & ~empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_tag;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < C_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/cnn_layer_accel_fas_rd_arb.sv
// Round-robin read arbiter sharing the stream-manager read port among the
// FAS read clients, with in-order return routing via an outstanding-tag FIFO.
module cnn_layer_accel_fas_rd_arb
  import cnn_layer_accel_fas_rd_arb_pkg::*;
#(
  parameter int unsigned C_FAS_ID          = 0,
  parameter int unsigned C_NUM_RD          = 4,
  parameter int unsigned C_ADDR_WIDTH      = 32,
  parameter int unsigned C_LEN_WIDTH       = 16,
  parameter int unsigned C_DATA_WIDTH      = 128,
  parameter int unsigned C_MAX_OUTSTANDING = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [C_NUM_RD-1:0]                    rd_req,
  input  logic [C_NUM_RD*C_ADDR_WIDTH-1:0]       rd_addr,
  input  logic [C_NUM_RD*C_LEN_WIDTH-1:0]        rd_len,
  output logic [C_NUM_RD-1:0]                    rd_req_ack,
  output logic                                   mem_rd_req,
  output logic [C_ADDR_WIDTH-1:0]                mem_rd_addr,
  output logic [C_LEN_WIDTH-1:0]                 mem_rd_len,
  output logic [7:0]                             mem_rd_fas_id,
  input  logic                                   mem_rd_ack,
  input  logic                                   mem_rd_data_valid,
  input  logic [C_DATA_WIDTH-1:0]                mem_rd_data,
  input  logic                                   mem_rd_data_last,
  output logic [C_NUM_RD-1:0]                    rd_data_valid,
  output logic [C_DATA_WIDTH-1:0]                rd_data,
  output logic [C_NUM_RD-1:0]                    rd_data_last,
  output logic [$clog2(C_MAX_OUTSTANDING):0]     outstanding_cnt,
  output logic                                   err_orphan
);

  arb_state_e               state_q, state_d;
  rd_tag_t                  rr_ptr_q, rr_ptr_d;
  rd_tag_t                  grant_q, grant_d;
  logic [C_ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [C_LEN_WIDTH-1:0]   len_q, len_d;
  logic [C_DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic [C_NUM_RD-1:0]      rvalid_q, rvalid_d;
  logic [C_NUM_RD-1:0]      rlast_q, rlast_d;
  logic                     err_q, err_d;

  logic [C_ADDR_WIDTH-1:0]  addr_arr [C_NUM_RD];
  logic [C_LEN_WIDTH-1:0]   len_arr  [C_NUM_RD];
  rd_tag_t                  cand;
  rd_tag_t                  sel;
  logic                     req_found;

  logic                     push, pop;
  rd_tag_t                  head_tag;
  logic                     fifo_full, fifo_empty;

  cnn_layer_accel_fas_rd_arb_tag_fifo #(
    .C_DEPTH (C_MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_tag (grant_q),
    .pop      (pop),
    .head_tag (head_tag),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (outstanding_cnt)
  );

  assign mem_rd_fas_id = 8'(C_FAS_ID);
  assign mem_rd_req    = (state_q == ST_ISSUE);
  assign mem_rd_addr   = addr_q;
  assign mem_rd_len    = len_q;
  assign rd_data_valid = rvalid_q;
  assign rd_data_last  = rlast_q;
  assign rd_data       = rdata_q;
  assign err_orphan    = err_q;

  // Unpack the flat per-client address/length buses.
  always_comb begin
    for (int unsigned i = 0; i < C_NUM_RD; i++) begin
      addr_arr[i] = rd_addr[i*C_ADDR_WIDTH +: C_ADDR_WIDTH];
      len_arr[i]  = rd_len[i*C_LEN_WIDTH +: C_LEN_WIDTH];
    end
  end

  // Pick the first requester at or after the round-robin pointer.
  always_comb begin
    req_found = 1'b0;
    sel       = '0;
    cand      = '0;
    for (int unsigned i = 0; i < C_NUM_RD; i++) begin
      cand = rd_tag_t'((32'(rr_ptr_q) + i) % C_NUM_RD);
      if (!req_found && rd_req[cand]) begin
        req_found = 1'b1;
        sel       = cand;
      end
    end
  end

  // Grant FSM: zero-length requests are acknowledged directly from IDLE.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    addr_d     = addr_q;
    len_d      = len_q;
    rd_req_ack = '0;
    push       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_found && !fifo_full) begin
          if (len_arr[sel] == '0) begin
            rd_req_ack[sel] = 1'b1;
            rr_ptr_d        = rr_next(sel, C_NUM_RD);
          end else begin
            grant_d = sel;
            addr_d  = addr_arr[sel];
            len_d   = len_arr[sel];
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (mem_rd_ack) begin
          rd_req_ack[grant_q] = 1'b1;
          push                = 1'b1;
          rr_ptr_d            = rr_next(grant_q, C_NUM_RD);
          state_d             = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Return path: route each beat to the FIFO-head client, pop on the last beat.
  always_comb begin
    rvalid_d = '0;
    rlast_d  = '0;
    rdata_d  = rdata_q;
    err_d    = err_q;
    pop      = 1'b0;
    if (mem_rd_data_valid) begin
      if (fifo_empty) begin
        err_d = 1'b1;
      end else begin
        rvalid_d[head_tag] = 1'b1;
        rdata_d            = mem_rd_data;
        if (mem_rd_data_last) begin
          rlast_d[head_tag] = 1'b1;
          pop               = 1'b1;
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= '0;
      rlast_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
      err_q    <= err_d;
    end
  end

endmodule
